multicycle_control_unit: RTL and testbench

- Multi-cycle RISC-V RV32I controller. Successor to the single-cycle combinational decoder.
- A Moore FSM sequences one instruction over 3–5 cycles through a shared ALU and a unified memory.
- Adds a memory ready handshake, a wait timeout, a full branch-condition set, R-type and LUI support, and a sticky trap state.
- Sits between the instruction register and the multicycle datapath (PC, IR, ALUOut, Data registers).

---
 rtl/multicycle_control_unit_pkg.sv | 75 +++++++
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/multicycle_control_unit_alu_decoder.sv | 43 ++++
 rtl/multicycle_control_unit.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and opcode constants for the multicycle RV32I controller.
package control_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_t;

  // Which ALU decode table applies in the current state.
  typedef enum logic [1:0] {
    CLS_ADD    = 2'd0,
    CLS_RTYPE  = 2'd1,
    CLS_ITYPE  = 2'd2,
    CLS_BRANCH = 2'd3
  } alu_class_t;

  // DECODE dispatch: legal opcode/funct3 pairs pick the next state, anything else traps.
  function automatic state_t dispatch(input logic [6:0] opcode, input logic [2:0] funct3);
    state_t s;
    s = TRAP;
    case (opcode)
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) s = MEMADR;
      OP_RTYPE:          s = EXECR;
      OP_ITYPE:          s = EXECI;
      OP_BRANCH:         if (funct3[2:1] != 2'b01) s = BRANCH;
      OP_JAL:            s = JAL;
      OP_LUI:            s = LUI;
      default:           s = TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle: instruction/status in, control strobes and selects out.
interface multicycle_control_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] instr;
  logic                  Zero;
  logic                  mem_ready;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  MemRead;
  logic                  IRWrite;
  logic                  RegWrite;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [2:0]            ImmSrc;
  logic [3:0]            ALUControl;
  logic                  trap;
  logic                  trap_cause;
  logic [3:0]            state_dbg;

  modport master (
    input  instr, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, MemRead, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
           trap, trap_cause, state_dbg
  );

  modport slave (
    output instr, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, MemRead, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
           trap, trap_cause, state_dbg
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU operation and branch-polarity decode.
module alu_decoder
  import control_pkg::*;
(
  input  alu_class_t cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_op_t    alu_ctl_o,
  output logic       taken_on_zero_o
);

  // beq/bge/bgeu are taken on Zero; bne/blt/bltu on !Zero.
  assign taken_on_zero_o = (funct3_i[0] == funct3_i[2]);

  // Operation select per instruction class.
  always_comb begin
    alu_ctl_o = ALU_ADD;
    case (cls_i)
      CLS_RTYPE, CLS_ITYPE: begin
        case (funct3_i)
          3'b000:  alu_ctl_o = (cls_i == CLS_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctl_o = ALU_SLL;
          3'b010:  alu_ctl_o = ALU_SLT;
          3'b011:  alu_ctl_o = ALU_SLTU;
          3'b100:  alu_ctl_o = ALU_XOR;
          3'b101:  alu_ctl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctl_o = ALU_OR;
          default: alu_ctl_o = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3_i[2:1])
          2'b00:   alu_ctl_o = ALU_SUB;
          2'b10:   alu_ctl_o = ALU_SLT;
          2'b11:   alu_ctl_o = ALU_SLTU;
          default: alu_ctl_o = ALU_ADD;
        endcase
      end
      default: alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with memory handshake, optional wait timeout and sticky trap.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TO_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              trap_cause_q, trap_cause_d;

  logic [DATA_WIDTH-1:0] instr_w;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic              unused_instr;

  alu_class_t        cls;
  alu_op_t           dec_alu;
  logic              taken_on_zero;
  logic              mem_wait;
  logic              to_hit;

  logic              pc_write, adr_src, mem_write, mem_read, ir_write, reg_write;
  logic [1:0]        result_src, alu_src_a, alu_src_b;
  imm_src_t          imm_src;
  alu_op_t           alu_sel;

  assign instr_w      = bus.instr;
  assign opcode       = instr_w[6:0];
  assign funct3       = instr_w[14:12];
  assign funct7b5     = instr_w[30];
  assign unused_instr = ^instr_w;

  assign cls = (state_q == EXECR)  ? CLS_RTYPE  :
               (state_q == EXECI)  ? CLS_ITYPE  :
               (state_q == BRANCH) ? CLS_BRANCH : CLS_ADD;

  alu_decoder u_alu_decoder (
    .cls_i           (cls),
    .funct3_i        (funct3),
    .funct7b5_i      (funct7b5),
    .alu_ctl_o       (dec_alu),
    .taken_on_zero_o (taken_on_zero)
  );

  // A memory-owning state is stalled when the access has not completed this cycle.
  assign mem_wait = ((state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE))
                    && !bus.mem_ready;
  assign to_hit   = (MEM_TIMEOUT != 0) && mem_wait && (to_cnt_q == TO_LIMIT);

  // State, timeout counter and trap cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      to_cnt_q     <= '0;
      trap_cause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // Next state and Moore outputs (gated by mem_ready/Zero where the state owns them).
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = IMM_I;
    alu_sel    = ALU_ADD;
    case (state_q)
      FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_B;
        state_d   = dispatch(opcode, funct3);
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_sel   = dec_alu;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_sel   = dec_alu;
        state_d   = ALUWB;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_sel   = dec_alu;
        pc_write  = taken_on_zero ? bus.Zero : !bus.Zero;
        state_d   = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_src   = IMM_J;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
    if (to_hit) state_d = TRAP;
  end

  // Stall counter clears on any state change; cause is latched on entry to TRAP.
  always_comb begin
    to_cnt_d     = to_cnt_q;
    trap_cause_d = trap_cause_q;
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (mem_wait && (MEM_TIMEOUT != 0)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if ((state_d == TRAP) && (state_q != TRAP)) trap_cause_d = to_hit;
  end

  // Strobes forced low while reset is held so nothing fires during an abandoned access.
  assign bus.PCWrite    = pc_write  & rst_n;
  assign bus.IRWrite    = ir_write  & rst_n;
  assign bus.RegWrite   = reg_write & rst_n;
  assign bus.MemWrite   = mem_write & rst_n;
  assign bus.MemRead    = mem_read  & rst_n;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_sel;
  assign bus.trap       = (state_q == TRAP);
  assign bus.trap_cause = trap_cause_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one task per scenario, hand-derived expectations.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_to_n;
  int   n_vec = 0;
  int   n_err = 0;

  multicycle_control_unit_if #(.DATA_WIDTH(32)) m ();
  multicycle_control_unit_if #(.DATA_WIDTH(32)) t ();

  multicycle_control_unit #(.DATA_WIDTH(32), .MEM_TIMEOUT(0), .TO_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  multicycle_control_unit #(.DATA_WIDTH(32), .MEM_TIMEOUT(4), .TO_W(8)) dut_to (
    .clk   (clk),
    .rst_n (rst_to_n),
    .bus   (t)
  );

  always #5 clk = ~clk;

  // Strobe bundles in order {PCWrite, IRWrite, RegWrite, MemWrite, MemRead}.
  logic [4:0] stb_m, stb_t;
  assign stb_m = {m.PCWrite, m.IRWrite, m.RegWrite, m.MemWrite, m.MemRead};
  assign stb_t = {t.PCWrite, t.IRWrite, t.RegWrite, t.MemWrite, t.MemRead};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_to_n = 1'b0;
    m.mem_ready = 1'b1; m.Zero = 1'b0; m.instr = 32'h00500093;
    t.mem_ready = 1'b0; t.Zero = 1'b0; t.instr = 32'h00500093;
    #7;
    n_vec++;
    if ({m.state_dbg, stb_m} !== {4'd0, 5'b00000}) begin
      n_err++;
      $display("FAIL reset_state_strobes got %h exp %h", {m.state_dbg, stb_m}, {4'd0, 5'b00000});
    end
    n_vec++;
    if ({m.trap, m.trap_cause} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_trap got %b exp 00", {m.trap, m.trap_cause});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (stb_m !== 5'b11001) begin
      n_err++;
      $display("FAIL reset_release_fetch got %b exp 11001", stb_m);
    end
  endtask

  task automatic test_addi();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    logic [4:0] eb [5] = '{5'b11001, 5'b00000, 5'b00000, 5'b00100, 5'b11001};
    m.instr = 32'h00500093; m.mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({m.state_dbg, stb_m} !== {es[i], eb[i]}) begin
        n_err++;
        $display("FAIL addi_cyc%0d got %h exp %h", i + 1, {m.state_dbg, stb_m}, {es[i], eb[i]});
      end
      if (i == 2) begin
        n_vec++;
        if ({m.ALUControl, m.ALUSrcA, m.ALUSrcB, m.ImmSrc} !== {4'd0, 2'b10, 2'b01, 3'd0}) begin
          n_err++;
          $display("FAIL addi_execi_sel got %h exp %h",
                   {m.ALUControl, m.ALUSrcA, m.ALUSrcB, m.ImmSrc}, {4'd0, 2'b10, 2'b01, 3'd0});
        end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_lw_wait();
    logic       rdy [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] es  [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [4:0] eb  [9] = '{5'b11001, 5'b00000, 5'b00000, 5'b00001, 5'b00001,
                            5'b00001, 5'b00001, 5'b00100, 5'b11001};
    m.instr = 32'h0000A103;
    for (int i = 0; i < 9; i++) begin
      m.mem_ready = rdy[i];
      #1;
      n_vec++;
      if ({m.state_dbg, stb_m} !== {es[i], eb[i]}) begin
        n_err++;
        $display("FAIL lw_cyc%0d got %h exp %h", i + 1, {m.state_dbg, stb_m}, {es[i], eb[i]});
      end
      if (i == 2) begin
        n_vec++;
        if ({m.ALUSrcA, m.ALUSrcB, m.ImmSrc} !== {2'b10, 2'b01, 3'd0}) begin
          n_err++;
          $display("FAIL lw_memadr_sel got %h exp %h", {m.ALUSrcA, m.ALUSrcB, m.ImmSrc}, {2'b10, 2'b01, 3'd0});
        end
      end
      if (i == 3) begin
        n_vec++;
        if (m.AdrSrc !== 1'b1) begin
          n_err++;
          $display("FAIL lw_adrsrc got %b exp 1", m.AdrSrc);
        end
      end
      if (i == 7) begin
        n_vec++;
        if (m.ResultSrc !== 2'b01) begin
          n_err++;
          $display("FAIL lw_resultsrc got %b exp 01", m.ResultSrc);
        end
      end
      if (i < 8) tick();
    end
  endtask

  task automatic test_branch();
    logic [31:0] bi [5] = '{32'h00208463, 32'h00208463, 32'h0020E463, 32'h0020D463, 32'h00209463};
    logic        bz [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        bp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  ba [5] = '{4'd1, 4'd1, 4'd6, 4'd5, 4'd1};
    m.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m.instr = bi[i]; m.Zero = 1'b0;
      tick();
      n_vec++;
      if ({m.state_dbg, m.ALUSrcA, m.ALUSrcB, m.ImmSrc} !== {4'd1, 2'b01, 2'b01, 3'd2}) begin
        n_err++;
        $display("FAIL br%0d_decode got %h exp %h", i,
                 {m.state_dbg, m.ALUSrcA, m.ALUSrcB, m.ImmSrc}, {4'd1, 2'b01, 2'b01, 3'd2});
      end
      tick();
      m.Zero = bz[i];
      #1;
      n_vec++;
      if ({m.state_dbg, stb_m, m.ALUControl} !== {4'd9, bp[i], 4'b0000, ba[i]}) begin
        n_err++;
        $display("FAIL br%0d_branch got %h exp %h", i,
                 {m.state_dbg, stb_m, m.ALUControl}, {4'd9, bp[i], 4'b0000, ba[i]});
      end
      tick();
      n_vec++;
      if (m.state_dbg !== 4'd0) begin
        n_err++;
        $display("FAIL br%0d_return got %0d exp 0", i, m.state_dbg);
      end
    end
    m.Zero = 1'b0;
  endtask

  task automatic test_jal();
    m.instr = 32'h008000EF; m.mem_ready = 1'b1;
    tick(); tick();
    n_vec++;
    if ({m.state_dbg, stb_m} !== {4'd10, 5'b10000}) begin
      n_err++;
      $display("FAIL jal_state got %h exp %h", {m.state_dbg, stb_m}, {4'd10, 5'b10000});
    end
    n_vec++;
    if ({m.ALUSrcA, m.ALUSrcB, m.ImmSrc, m.ALUControl} !== {2'b01, 2'b10, 3'd3, 4'd0}) begin
      n_err++;
      $display("FAIL jal_sel got %h exp %h", {m.ALUSrcA, m.ALUSrcB, m.ImmSrc, m.ALUControl},
               {2'b01, 2'b10, 3'd3, 4'd0});
    end
    tick();
    n_vec++;
    if ({m.state_dbg, stb_m} !== {4'd8, 5'b00100}) begin
      n_err++;
      $display("FAIL jal_aluwb got %h exp %h", {m.state_dbg, stb_m}, {4'd8, 5'b00100});
    end
    tick();
  endtask

  task automatic test_exec();
    // expected {state, ALUControl, ALUSrcA, ALUSrcB, ImmSrc}
    logic [31:0] xi [5] = '{32'h402081B3, 32'h4020D1B3, 32'h4030D093, 32'hC0000093, 32'h000010B7};
    logic [14:0] xe [5] = '{{4'd6, 4'd1, 2'b10, 2'b00, 3'd0},
                            {4'd6, 4'd9, 2'b10, 2'b00, 3'd0},
                            {4'd7, 4'd9, 2'b10, 2'b01, 3'd0},
                            {4'd7, 4'd0, 2'b10, 2'b01, 3'd0},
                            {4'd11, 4'd0, 2'b11, 2'b01, 3'd4}};
    m.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m.instr = xi[i];
      tick(); tick();
      n_vec++;
      if ({m.state_dbg, m.ALUControl, m.ALUSrcA, m.ALUSrcB, m.ImmSrc} !== xe[i]) begin
        n_err++;
        $display("FAIL exec%0d got %h exp %h", i,
                 {m.state_dbg, m.ALUControl, m.ALUSrcA, m.ALUSrcB, m.ImmSrc}, xe[i]);
      end
      tick();
      n_vec++;
      if ({m.state_dbg, stb_m, m.ResultSrc} !== {4'd8, 5'b00100, 2'b00}) begin
        n_err++;
        $display("FAIL exec%0d_aluwb got %h exp %h", i, {m.state_dbg, stb_m, m.ResultSrc},
                 {4'd8, 5'b00100, 2'b00});
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ii [3] = '{32'h0000007F, 32'h00008103, 32'h0020A463};
    m.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m.instr = ii[i];
      tick(); tick();
      n_vec++;
      if ({m.state_dbg, stb_m, m.trap, m.trap_cause} !== {4'd12, 5'b00000, 2'b10}) begin
        n_err++;
        $display("FAIL illegal%0d_trap got %h exp %h", i, {m.state_dbg, stb_m, m.trap, m.trap_cause},
                 {4'd12, 5'b00000, 2'b10});
      end
      tick();
      n_vec++;
      if ({m.state_dbg, m.trap} !== {4'd12, 1'b1}) begin
        n_err++;
        $display("FAIL illegal%0d_sticky got %h exp %h", i, {m.state_dbg, m.trap}, {4'd12, 1'b1});
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({m.state_dbg, stb_m, m.trap} !== {4'd0, 5'b00000, 1'b0}) begin
        n_err++;
        $display("FAIL illegal%0d_reset got %h exp %h", i, {m.state_dbg, stb_m, m.trap},
                 {4'd0, 5'b00000, 1'b0});
      end
      rst_n = 1'b1;
      #1;
    end
  endtask

  task automatic test_store_reset();
    m.instr = 32'h0020A023; m.mem_ready = 1'b1;
    // Store completing on the first MEMWRITE cycle
    tick(); tick();
    n_vec++;
    if ({m.state_dbg, m.ImmSrc} !== {4'd2, 3'd1}) begin
      n_err++;
      $display("FAIL sw_memadr got %h exp %h", {m.state_dbg, m.ImmSrc}, {4'd2, 3'd1});
    end
    tick();
    n_vec++;
    if ({m.state_dbg, stb_m, m.AdrSrc} !== {4'd5, 5'b00010, 1'b1}) begin
      n_err++;
      $display("FAIL sw_write got %h exp %h", {m.state_dbg, stb_m, m.AdrSrc}, {4'd5, 5'b00010, 1'b1});
    end
    tick();
    n_vec++;
    if (m.state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL sw_done got %0d exp 0", m.state_dbg);
    end
    // Store stalled, then abandoned by an asynchronous reset
    tick(); tick();
    m.mem_ready = 1'b0;
    tick(); tick();
    n_vec++;
    if ({m.state_dbg, stb_m} !== {4'd5, 5'b00010}) begin
      n_err++;
      $display("FAIL sw_held got %h exp %h", {m.state_dbg, stb_m}, {4'd5, 5'b00010});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({m.state_dbg, stb_m} !== {4'd0, 5'b00000}) begin
      n_err++;
      $display("FAIL sw_async_reset got %h exp %h", {m.state_dbg, stb_m}, {4'd0, 5'b00000});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    t.mem_ready = 1'b0;
    rst_to_n = 1'b0;
    #1;
    rst_to_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if ({t.state_dbg, stb_t, t.trap} !== {4'd0, 5'b00001, 1'b0}) begin
        n_err++;
        $display("FAIL to_wait%0d got %h exp %h", i, {t.state_dbg, stb_t, t.trap}, {4'd0, 5'b00001, 1'b0});
      end
    end
    tick();
    n_vec++;
    if ({t.state_dbg, stb_t, t.trap, t.trap_cause} !== {4'd12, 5'b00000, 2'b11}) begin
      n_err++;
      $display("FAIL to_trap got %h exp %h", {t.state_dbg, stb_t, t.trap, t.trap_cause},
               {4'd12, 5'b00000, 2'b11});
    end
    tick();
    t.mem_ready = 1'b1;
    #1;
    n_vec++;
    if ({t.state_dbg, stb_t, t.trap, t.trap_cause} !== {4'd12, 5'b00000, 2'b11}) begin
      n_err++;
      $display("FAIL to_sticky got %h exp %h", {t.state_dbg, stb_t, t.trap, t.trap_cause},
               {4'd12, 5'b00000, 2'b11});
    end
    t.mem_ready = 1'b0;
    rst_to_n = 1'b0;
    #1;
    n_vec++;
    if ({t.state_dbg, t.trap, t.trap_cause} !== {4'd0, 2'b00}) begin
      n_err++;
      $display("FAIL to_reset got %h exp %h", {t.state_dbg, t.trap, t.trap_cause}, {4'd0, 2'b00});
    end
    rst_to_n = 1'b1;
    // Completion on the limit cycle wins over the timeout
    for (int i = 0; i < 4; i++) tick();
    t.mem_ready = 1'b1;
    #1;
    n_vec++;
    if ({t.state_dbg, stb_t} !== {4'd0, 5'b11001}) begin
      n_err++;
      $display("FAIL to_limit_ready got %h exp %h", {t.state_dbg, stb_t}, {4'd0, 5'b11001});
    end
    tick();
    n_vec++;
    if ({t.state_dbg, t.trap} !== {4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL to_completion_wins got %h exp %h", {t.state_dbg, t.trap}, {4'd1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_jal();
    test_exec();
    test_illegal();
    test_store_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
